// File: rtl/if_stage_pkg.sv
// -----------------------------------------------------------------------------
// if_stage_pkg
// Shared constants and types for the pipelined LoongArch CPU stages.
//   FS_TO_DS_BUS_WD : IF->ID payload width, packed {inst[31:0], pc[31:0]}
//   BR_BUS_WD       : ID->IF branch bus width, packed {br_taken, br_target[31:0]}
//   DS_TO_ES_BUS_WD : ID->EX payload width, used by the later stages
//   RESET_PC        : address of the first instruction fetched after reset
// -----------------------------------------------------------------------------
package if_stage_pkg;

    localparam int FS_TO_DS_BUS_WD = 64;
    localparam int BR_BUS_WD       = 33;
    localparam int DS_TO_ES_BUS_WD = 150;

    localparam logic [31:0] RESET_PC = 32'h1c000000;

    // Field view of the branch bus coming back from ID.
    typedef struct packed {
        logic        taken;
        logic [31:0] target;
    } br_bus_t;

    // Sequential successor of a PC; 32-bit add that wraps silently.
    function automatic logic [31:0] seq_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage
// Instruction-fetch stage: pre-IF next-PC select, inst SRAM request, the IF
// stage register and a one-entry instruction buffer that holds the returned
// instruction while ID stalls. Branch redirects from ID cancel the wrong-path
// instruction currently in IF and fetch the target in the same cycle.
//
// Ports:
//   clk             in   clock
//   reset           in   asynchronous, active-high reset
//   ds_allowin      in   ID can accept a new instruction this cycle
//   br_bus          in   {br_taken, br_target}, single-cycle redirect from ID
//   fs_to_ds_valid  out  IF presents a valid instruction to ID
//   fs_to_ds_bus    out  {inst, pc} payload to ID
//   inst_sram_en    out  fetch request enable
//   inst_sram_we    out  byte write enables (always 0)
//   inst_sram_addr  out  fetch address (nextpc)
//   inst_sram_wdata out  write data (always 0)
//   inst_sram_rdata in   instruction data, valid one cycle after a request
// -----------------------------------------------------------------------------
module if_stage
    import if_stage_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ds_allowin,
    input  logic [BR_BUS_WD-1:0]       br_bus,
    output logic                       fs_to_ds_valid,
    output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
    output logic                       inst_sram_en,
    output logic [3:0]                 inst_sram_we,
    output logic [31:0]                inst_sram_addr,
    output logic [31:0]                inst_sram_wdata,
    input  logic [31:0]                inst_sram_rdata
);

    br_bus_t     br;
    logic        to_fs_valid;
    logic        fs_ready_go;
    logic        fs_cancel;
    logic        fs_allowin;
    logic [31:0] nextpc;
    logic [31:0] fs_inst;

    logic        fs_valid;
    logic [31:0] fs_pc;
    logic        inst_buf_valid;
    logic [31:0] inst_buf;
    logic        br_pend;
    logic [31:0] br_pend_target;

    assign br          = br_bus;
    assign to_fs_valid = ~reset;
    assign fs_ready_go = 1'b1;
    assign fs_cancel   = br.taken;

    // A redirect always opens IF so the target is requested in the same cycle
    // that the wrong-path instruction is dropped.
    assign fs_allowin = ~fs_valid | (fs_ready_go & ds_allowin) | fs_cancel;

    assign nextpc = br.taken ? br.target      :
                    br_pend  ? br_pend_target :
                               seq_pc(fs_pc);

    assign inst_sram_en    = to_fs_valid & fs_allowin;
    assign inst_sram_we    = 4'h0;
    assign inst_sram_addr  = nextpc;
    assign inst_sram_wdata = 32'h0;

    // The SRAM only holds its data for one cycle, so a stalled instruction is
    // served from the buffer after its first IF cycle.
    assign fs_inst        = inst_buf_valid ? inst_buf : inst_sram_rdata;
    assign fs_to_ds_valid = fs_valid & fs_ready_go & ~fs_cancel;
    assign fs_to_ds_bus   = {fs_inst, fs_pc};

    // IF stage register: advances whenever a request fires.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fs_valid <= 1'b0;
            fs_pc    <= RESET_PC - 32'd4;
        end else if (inst_sram_en) begin
            fs_valid <= 1'b1;
            fs_pc    <= nextpc;
        end
    end

    // Remembers a redirect that arrived while no request could be issued;
    // consumed by the next request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            br_pend        <= 1'b0;
            br_pend_target <= 32'h0;
        end else if (inst_sram_en) begin
            br_pend <= 1'b0;
        end else if (br.taken) begin
            br_pend        <= 1'b1;
            br_pend_target <= br.target;
        end
    end

    // One-entry instruction buffer: captured on the first stalled IF cycle,
    // dropped when ID takes the instruction or the instruction is cancelled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inst_buf_valid <= 1'b0;
            inst_buf       <= 32'h0;
        end else if ((fs_valid & ds_allowin) | fs_cancel) begin
            inst_buf_valid <= 1'b0;
        end else if (fs_valid & ~inst_buf_valid & ~ds_allowin) begin
            inst_buf_valid <= 1'b1;
            inst_buf       <= inst_sram_rdata;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// -----------------------------------------------------------------------------
// tb_if_stage
// Self-checking bench for if_stage. A behavioural inst SRAM returns
// address-tagged data one cycle after an enabled request and garbage
// otherwise. A table of per-cycle vectors walks through sequential fetch,
// a stall, a redirect, a redirect during a stall and address wrap; a
// hand-written sequence covers asynchronous reset mid-stream.
// -----------------------------------------------------------------------------
module tb_if_stage;
    import if_stage_pkg::*;

    logic                       clk;
    logic                       reset;
    logic                       ds_allowin;
    logic [BR_BUS_WD-1:0]       br_bus;
    logic                       fs_to_ds_valid;
    logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus;
    logic                       inst_sram_en;
    logic [3:0]                 inst_sram_we;
    logic [31:0]                inst_sram_addr;
    logic [31:0]                inst_sram_wdata;
    logic [31:0]                inst_sram_rdata;

    int checks;
    int failures;

    typedef struct {
        logic        ds_allowin;
        logic        br_taken;
        logic [31:0] br_target;
        logic        exp_en;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    localparam int NUM_VECS = 16;
    vec_t vecs [NUM_VECS];

    if_stage dut (
        .clk             (clk),
        .reset           (reset),
        .ds_allowin      (ds_allowin),
        .br_bus          (br_bus),
        .fs_to_ds_valid  (fs_to_ds_valid),
        .fs_to_ds_bus    (fs_to_ds_bus),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_we    (inst_sram_we),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_wdata (inst_sram_wdata),
        .inst_sram_rdata (inst_sram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction word the SRAM model stores at a given address.
    function automatic logic [31:0] tag(input logic [31:0] a);
        return a ^ 32'h5a5a_a5a5;
    endfunction

    // SRAM model: data one cycle after an enabled request, garbage otherwise.
    always @(posedge clk) begin
        if (inst_sram_en)
            inst_sram_rdata <= tag(inst_sram_addr);
        else
            inst_sram_rdata <= $urandom() | 32'h0000_0003;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %08h expected %08h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        ds_allowin = v.ds_allowin;
        br_bus     = {v.br_taken, v.br_target};
        #1;
    endtask

    task automatic checkVector(input int idx, input vec_t v);
        string sfx;
        sfx = $sformatf("[%0d]", idx);
        checkOutput({"en", sfx}, {31'h0, inst_sram_en}, {31'h0, v.exp_en});
        checkOutput({"addr", sfx}, inst_sram_addr, v.exp_addr);
        checkOutput({"valid", sfx}, {31'h0, fs_to_ds_valid}, {31'h0, v.exp_valid});
        if (v.exp_valid) begin
            checkOutput({"pc", sfx}, fs_to_ds_bus[31:0], v.exp_pc);
            checkOutput({"inst", sfx}, fs_to_ds_bus[63:32], tag(v.exp_pc));
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        checks          = 0;
        failures        = 0;
        reset           = 1'b1;
        ds_allowin      = 1'b1;
        br_bus          = '0;
        inst_sram_rdata = 32'h0;

        //          ds   br    target         en    addr           valid pc
        vecs[0]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h1c000000, 1'b0, 32'h0};
        vecs[1]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h1c000004, 1'b1, 32'h1c000000};
        vecs[2]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h1c000008, 1'b1, 32'h1c000004};
        // stall for three cycles with 1c000008 in IF
        vecs[3]  = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h1c00000c, 1'b1, 32'h1c000008};
        vecs[4]  = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h1c00000c, 1'b1, 32'h1c000008};
        vecs[5]  = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h1c00000c, 1'b1, 32'h1c000008};
        vecs[6]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h1c00000c, 1'b1, 32'h1c000008};
        vecs[7]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h1c000010, 1'b1, 32'h1c00000c};
        // redirect while 1c000010 is in IF
        vecs[8]  = '{1'b1, 1'b1, 32'h1c000100, 1'b1, 32'h1c000100, 1'b0, 32'h0};
        vecs[9]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h1c000104, 1'b1, 32'h1c000100};
        // stall, then redirect while the buffer holds 1c000104
        vecs[10] = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h1c000108, 1'b1, 32'h1c000104};
        vecs[11] = '{1'b0, 1'b1, 32'h1c000200, 1'b1, 32'h1c000200, 1'b0, 32'h0};
        vecs[12] = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h1c000204, 1'b1, 32'h1c000200};
        // fs_pc taken to the top of the address space, then wrap to 0
        vecs[13] = '{1'b1, 1'b1, 32'hfffffffc, 1'b1, 32'hfffffffc, 1'b0, 32'h0};
        vecs[14] = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h00000000, 1'b1, 32'hfffffffc};
        vecs[15] = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h00000004, 1'b1, 32'h00000000};

        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset_en", {31'h0, inst_sram_en}, 32'h0);
        checkOutput("reset_valid", {31'h0, fs_to_ds_valid}, 32'h0);
        checkOutput("sram_we", {28'h0, inst_sram_we}, 32'h0);
        checkOutput("sram_wdata", inst_sram_wdata, 32'h0);

        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < NUM_VECS; i++) begin
            applyStimulus(vecs[i]);
            checkVector(i, vecs[i]);
            @(negedge clk);
        end

        // Asynchronous reset between clock edges, with a redirect presented
        // during reset that must be discarded.
        ds_allowin = 1'b1;
        br_bus     = '0;
        #3;
        reset  = 1'b1;
        br_bus = {1'b1, 32'h1c000300};
        #1;
        checkOutput("arst_fs_valid", {31'h0, dut.fs_valid}, 32'h0);
        checkOutput("arst_en", {31'h0, inst_sram_en}, 32'h0);
        checkOutput("arst_valid", {31'h0, fs_to_ds_valid}, 32'h0);
        @(negedge clk);
        #1;
        checkOutput("arst_hold_en", {31'h0, inst_sram_en}, 32'h0);
        checkOutput("arst_hold_valid", {31'h0, fs_to_ds_valid}, 32'h0);
        @(negedge clk);
        reset  = 1'b0;
        br_bus = '0;
        #1;
        checkOutput("restart_en", {31'h0, inst_sram_en}, 32'h1);
        checkOutput("restart_addr", inst_sram_addr, 32'h1c000000);
        checkOutput("restart_valid0", {31'h0, fs_to_ds_valid}, 32'h0);
        @(negedge clk);
        #1;
        checkOutput("restart_valid1", {31'h0, fs_to_ds_valid}, 32'h1);
        checkOutput("restart_pc", fs_to_ds_bus[31:0], 32'h1c000000);
        checkOutput("restart_inst", fs_to_ds_bus[63:32], tag(32'h1c000000));
        checkOutput("restart_addr1", inst_sram_addr, 32'h1c000004);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage for the 5-stage pipelined LoongArch CPU; sits directly upstream of the decode stage (ID).
- Combines a pre-IF next-PC select, the inst SRAM request, and the IF stage register.
- Holds the returned instruction in a one-entry buffer while ID stalls.
- Accepts branch redirects from ID and cancels the wrong-path instruction.

Parameters:
- RESET_PC, 32'h1c000000, address of the first instruction fetched after reset.
- FS_TO_DS_BUS_WD, 64, width of the IF->ID payload, packed {fs_inst[31:0], fs_pc[31:0]}.
- BR_BUS_WD, 33, width of the branch bus, packed {br_taken, br_target[31:0]}.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- ds_allowin  in  1  ID can accept a new instruction this cycle.
- br_bus  in  BR_BUS_WD  single-cycle redirect from ID; valid only when br_taken=1.
- fs_to_ds_valid  out  1  IF presents a valid instruction to ID.
- fs_to_ds_bus  out  FS_TO_DS_BUS_WD  {inst, pc} payload to ID.
- inst_sram_en  out  1  fetch request enable.
- inst_sram_we  out  4  byte write enables; constant 4'h0.
- inst_sram_addr  out  32  fetch address (nextpc).
- inst_sram_wdata  out  32  constant 32'h0.
- inst_sram_rdata  in  32  instruction data; valid exactly one cycle after an enabled request, undefined otherwise.

Behaviour:
- Regs: fs_valid (reset 0); fs_pc (reset RESET_PC-4 = 32'h1bfffffc); inst_buf/inst_buf_valid (reset 0/0); br_pend/br_pend_target (reset 0/0).
- All registers reset asynchronously on reset=1. A reset mid-operation drops any in-flight instruction and any pending redirect.
- During reset: inst_sram_en=0 and fs_to_ds_valid=0.
- to_fs_valid = ~reset.
- fs_ready_go = 1.
- fs_cancel = br_taken.
- fs_allowin = ~fs_valid | (fs_ready_go & ds_allowin) | fs_cancel.
- nextpc, in priority order: br_taken ? br_target : br_pend ? br_pend_target : fs_pc+4.
  - Addition is 32-bit and wraps silently.
  - Bits [1:0] are passed through unchecked.
- inst_sram_en = to_fs_valid & fs_allowin. inst_sram_addr = nextpc.
- Fire (edge with inst_sram_en=1): fs_pc<=nextpc and fs_valid<=1. br_pend is cleared at the same edge.
- Fetch latency: request at cycle N; instruction is presented to ID combinationally in cycle N+1 (first IF cycle).
- If fs_allowin=0 and no request is issued, fs_valid holds.
- fs_inst = inst_buf_valid ? inst_buf : inst_sram_rdata.
- Instruction buffer:
  - Capture: in the first IF cycle (inst_buf_valid=0), if fs_valid & ~ds_allowin & ~fs_cancel, then inst_buf<=inst_sram_rdata and inst_buf_valid<=1.
  - Clear: inst_buf_valid<=0 on any edge where fs_valid & ds_allowin, or fs_cancel.
- fs_to_ds_valid = fs_valid & fs_ready_go & ~fs_cancel.
- fs_to_ds_bus = {fs_inst, fs_pc}.
- Branch redirect:
  - br_taken is a one-cycle pulse from ID when the branch leaves ID.
  - The instruction in IF that cycle is the wrong path; it is suppressed by fs_cancel.
  - fs_allowin is forced high, so the target is requested that same cycle.
  - If to_fs_valid=0 that cycle (reset), the redirect is discarded.
  - br_pend exists only for robustness. It is set if br_taken arrives while inst_sram_en=0 for a non-reset reason, and it is used on the next issue.
- Simultaneous events:
  - br_taken together with ds_allowin=0: cancel wins; buffer cleared; target fetched.
  - br_taken while inst_buf_valid=1: buffer cleared.
  - Stall lasting multiple cycles: buffer content and fs_pc stay stable; inst_sram_en=0 throughout.
- No exceptions, no AXI, no multi-cycle SRAM latency in this revision.

Decomposition:
- Shared package/header (mycpu.h style defines): FS_TO_DS_BUS_WD, BR_BUS_WD, DS_TO_ES_BUS_WD (for later stages), RESET_PC.
- No sub-module required. The next-PC mux and the instruction buffer stay inline.
- ID, EX, MEM and WB are separate sibling stage modules wired in mycpu_top.

Test Plan:
- Reset release with ds_allowin=1 and a SRAM model returning addr-tagged data:
  - first request has inst_sram_addr=32'h1c000000;
  - next cycle, fs_to_ds_bus={data@1c000000, 32'h1c000000} with valid=1;
  - addresses then increment by 4 every cycle.
- Stall: ds_allowin=0 for 3 cycles while 32'h1c000008 is in IF:
  - inst_sram_en=0 for those cycles;
  - fs_to_ds_bus holds {inst@1c000008, 1c000008} from the buffer although rdata is driven to X/garbage;
  - on release, the next request is 32'h1c00000c.
- Redirect: br_taken=1, br_target=32'h1c000100 while 32'h1c000010 is in IF:
  - fs_to_ds_valid=0 that cycle;
  - inst_sram_addr=32'h1c000100;
  - next cycle, pc=32'h1c000100 is valid.
- Redirect during stall: br_taken=1 with ds_allowin=0 and inst_buf_valid=1:
  - buffer cleared;
  - target 32'h1c000200 fetched the same cycle;
  - the stale instruction never reaches ID.
- Async reset asserted mid-stream between clock edges:
  - fs_valid, inst_sram_en and fs_to_ds_valid go 0 immediately;
  - after release, fetch restarts at 32'h1c000000.
- Wrap: force fs_pc=32'hfffffffc in sim:
  - next sequential request address is 32'h00000000.
